// File: rtl/program_launcher.sv
// Host-side start/ack run launcher: resets the processor, pulses start, times the ack.
// Optional LAUNCH_STATS_EN adds run count and max-latency outputs.
module program_launcher #(
    parameter int DUT_RST_CYCLES = 2,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 8192,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             ack,
    output logic             dut_reset,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             timeout,
`ifdef LAUNCH_STATS_EN
    output logic [CNT_W-1:0] runs,
    output logic [CNT_W-1:0] max_cycles,
`endif
    output logic [CNT_W-1:0] cycles
);

    localparam int PH_MAX0 = (DUT_RST_CYCLES > START_CYCLES) ? DUT_RST_CYCLES : START_CYCLES;
    localparam int PH_MAX  = (TIMEOUT_CYCLES > PH_MAX0) ? TIMEOUT_CYCLES : PH_MAX0;
    localparam int PH_W    = $clog2(PH_MAX + 1);

    localparam logic [PH_W-1:0] RST_LD = PH_W'(DUT_RST_CYCLES - 1);
    localparam logic [PH_W-1:0] STA_LD = PH_W'(START_CYCLES - 1);
    localparam logic [PH_W-1:0] TMO_LD = PH_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_DUT,
        ARM,
        START,
        WAIT_ACK,
        FINISH
    } state_t;

    state_t           state_q;
    logic [PH_W-1:0]  ph_q;
    logic             dut_reset_q;
    logic             start_q;
    logic             busy_q;
    logic             done_q;
    logic             timeout_q;
    logic [CNT_W-1:0] cycles_q;
`ifdef LAUNCH_STATS_EN
    logic [CNT_W-1:0] runs_q;
    logic [CNT_W-1:0] max_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ph_q        <= '0;
            dut_reset_q <= 1'b0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            cycles_q    <= '0;
`ifdef LAUNCH_STATS_EN
            runs_q      <= '0;
            max_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q     <= RST_DUT;
                        dut_reset_q <= 1'b1;
                        busy_q      <= 1'b1;
                        cycles_q    <= '0;
                        timeout_q   <= 1'b0;
                        ph_q        <= RST_LD;
                    end
                end
                RST_DUT: begin
                    if (ph_q == '0) begin
                        state_q     <= ARM;
                        dut_reset_q <= 1'b0;
                    end else begin
                        ph_q <= ph_q - PH_W'(1);
                    end
                end
                ARM: begin
                    state_q <= START;
                    start_q <= 1'b1;
                    ph_q    <= STA_LD;
                end
                START: begin
                    if (ph_q == '0) begin
                        state_q <= WAIT_ACK;
                        start_q <= 1'b0;
                        ph_q    <= TMO_LD;
                    end else begin
                        ph_q <= ph_q - PH_W'(1);
                    end
                end
                WAIT_ACK: begin
                    // ack takes priority over the terminal count
                    if (ack) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
`ifdef LAUNCH_STATS_EN
                        if (runs_q != '1) runs_q <= runs_q + CNT_W'(1);
                        if (cycles_q > max_q) max_q <= cycles_q;
`endif
                    end else begin
                        if (cycles_q != '1) cycles_q <= cycles_q + CNT_W'(1);
                        if (ph_q == '0) begin
                            state_q   <= FINISH;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b1;
`ifdef LAUNCH_STATS_EN
                            if (runs_q != '1) runs_q <= runs_q + CNT_W'(1);
`endif
                        end else begin
                            ph_q <= ph_q - PH_W'(1);
                        end
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    dut_reset_q <= 1'b0;
                    start_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign dut_reset = dut_reset_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;
`ifdef LAUNCH_STATS_EN
    assign runs       = runs_q;
    assign max_cycles = max_q;
`endif

endmodule

// File: tb/tb_program_launcher.sv
// Bench for program_launcher: offset-based run model plus directed runs.
// A second instance with a narrow counter exercises cycles saturation.
module tb_program_launcher;

    localparam int TO = 100;
    localparam int W  = 16;
    localparam int WS = 4;
    localparam int SAT = (1 << WS) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic go = 1'b0;
    logic ack = 1'b0;

    logic dut_reset, start, busy, done, timeout;
    logic [W-1:0] cycles;
    logic s_dut_reset, s_start, s_busy, s_done, s_timeout;
    logic [WS-1:0] s_cycles;
`ifdef LAUNCH_STATS_EN
    logic [W-1:0] runs, max_cycles;
    logic [WS-1:0] s_runs, s_max_cycles;
`endif

    program_launcher #(
        .DUT_RST_CYCLES(2), .START_CYCLES(4), .TIMEOUT_CYCLES(TO), .CNT_W(W)
    ) u_dut (
        .clk(clk), .reset(rst_n), .go(go), .ack(ack),
        .dut_reset(dut_reset), .start(start), .busy(busy),
        .done(done), .timeout(timeout),
`ifdef LAUNCH_STATS_EN
        .runs(runs), .max_cycles(max_cycles),
`endif
        .cycles(cycles)
    );

    program_launcher #(
        .DUT_RST_CYCLES(2), .START_CYCLES(4), .TIMEOUT_CYCLES(TO), .CNT_W(WS)
    ) u_sat (
        .clk(clk), .reset(rst_n), .go(go), .ack(ack),
        .dut_reset(s_dut_reset), .start(s_start), .busy(s_busy),
        .done(s_done), .timeout(s_timeout),
`ifdef LAUNCH_STATS_EN
        .runs(s_runs), .max_cycles(s_max_cycles),
`endif
        .cycles(s_cycles)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_off is the number of edges since go was accepted (-1 when idle).
    // Offsets 0-1 reset, 2 arm, 3-6 start, 7 onward waiting for ack.
    int m_off = -1;
    bit m_fin = 0;
    int m_zeros = 0;
    bit m_to = 0;
    int m_runs = 0;
    int m_max = 0;

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void m_finish(bit t);
        m_fin = 1;
        m_off = -1;
        m_to = t;
        m_runs++;
        if (!t && m_zeros > m_max) m_max = m_zeros;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_off = -1; m_fin = 0; m_zeros = 0;
                m_to = 0; m_runs = 0; m_max = 0;
            end else if (m_fin) begin
                m_fin = 0;
            end else if (m_off < 0) begin
                if (go) begin
                    m_off = 0; m_zeros = 0; m_to = 0;
                end
            end else if (m_off < 7) begin
                m_off++;
            end else if (ack) begin
                m_finish(1'b0);
            end else begin
                m_zeros++;
                if (m_zeros == TO) m_finish(1'b1);
            end
        end
    end

    always @(negedge clk) begin
        logic [4:0] e_flags, a_flags, s_flags;
        logic [W-1:0] e_cyc;
        logic [WS-1:0] e_scyc;
        e_flags = {(m_off >= 0 && m_off <= 1), (m_off >= 3 && m_off <= 6),
                   (m_off >= 0 || m_fin), m_fin, m_to};
        a_flags = {dut_reset, start, busy, done, timeout};
        s_flags = {s_dut_reset, s_start, s_busy, s_done, s_timeout};
        e_cyc = W'(m_zeros);
        e_scyc = WS'(imin(m_zeros, SAT));
        checks++;
        if (a_flags !== e_flags || cycles !== e_cyc ||
            s_flags !== e_flags || s_cycles !== e_scyc) begin
            errors++;
            $display("FAIL model_cmp t=%0t flags got %b want %b sat %b cyc got %0d want %0d sat got %0d want %0d",
                     $time, a_flags, e_flags, s_flags, cycles, e_cyc, s_cycles, e_scyc);
        end
`ifdef LAUNCH_STATS_EN
        checks++;
        if (runs !== W'(m_runs) || max_cycles !== W'(m_max) ||
            s_runs !== WS'(imin(m_runs, SAT)) || s_max_cycles !== WS'(imin(m_max, SAT))) begin
            errors++;
            $display("FAIL stats_cmp t=%0t runs got %0d want %0d max got %0d want %0d",
                     $time, runs, m_runs, max_cycles, m_max);
        end
`endif
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n >= 0: raise ack n cycles after start falls; n < 0: never ack.
    task automatic do_run(input int n, input bit hold,
                          output int wc, output int rc, output int sc, output int wt);
        bit ok;
        go = 1'b1;
        wc = 0; rc = 0; sc = 0; wt = 0; ok = 0;
        while (!dut_reset && wc < 6) begin
            tick();
            wc++;
        end
        if (!hold) go = 1'b0;
        if (!dut_reset) begin
            chk("run_accept_timeout", 0, 1);
            return;
        end
        for (int i = 0; i < 40; i++) begin
            if (dut_reset) rc++;
            if (start) sc++;
            if (sc > 0 && !start) begin
                ok = 1;
                break;
            end
            tick();
        end
        if (!ok) begin
            chk("start_fall_timeout", 0, 1);
            return;
        end
        if (n >= 0) begin
            repeat (n) @(posedge clk);
            #1;
            ack = 1'b1;
            tick();
            chk("done_after_ack", done, 1);
            ack = 1'b0;
        end else begin
            for (int i = 0; i < 300; i++) begin
                tick();
                wt++;
                if (done) break;
            end
            chk("timeout_done", done, 1);
        end
    endtask

    int wc, rc, sc, wt;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", {dut_reset, start, done, timeout}, 0);
        chk("rst_cycles", cycles, 0);
        rst_n = 1'b1;
        tick();

        do_run(37, 1'b0, wc, rc, sc, wt);
        chk("r1_rst_len", rc, 2);
        chk("r1_start_len", sc, 4);
        chk("r1_cycles", cycles, 37);
        chk("r1_timeout", timeout, 0);
        repeat (3) tick();

        ack = 1'b1;
        repeat (2) tick();
        do_run(0, 1'b0, wc, rc, sc, wt);
        chk("stale_cycles", cycles, 0);
        repeat (2) tick();

        do_run(-1, 1'b0, wc, rc, sc, wt);
        chk("to_wait_len", wt, 100);
        chk("to_flag", timeout, 1);
        chk("to_cycles", cycles, 100);
        chk("to_sat_cycles", s_cycles, 15);
        repeat (2) tick();

        do_run(10, 1'b1, wc, rc, sc, wt);
        chk("b2b_c1", cycles, 10);
        do_run(20, 1'b0, wc, rc, sc, wt);
        chk("b2b_gap", wc, 2);
        chk("b2b_c2", cycles, 20);
        chk("b2b_to_clear", timeout, 0);
        repeat (3) tick();

        go = 1'b1;
        for (int i = 0; i < 20 && !start; i++) tick();
        go = 1'b0;
        chk("mid_start_seen", start, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_start", start, 0);
        chk("mid_busy", busy, 0);
        repeat (2) tick();
        chk("mid_done", done, 0);
        rst_n = 1'b1;
        tick();
        do_run(5, 1'b0, wc, rc, sc, wt);
        chk("post_rst_cycles", cycles, 5);
        chk("post_rst_len", rc + sc, 6);
        repeat (2) tick();

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_run(15, 1'b0, wc, rc, sc, wt);
        do_run(40, 1'b0, wc, rc, sc, wt);
        chk("st_c40", cycles, 40);
        do_run(-1, 1'b0, wc, rc, sc, wt);
        chk("st_to", timeout, 1);
`ifdef LAUNCH_STATS_EN
        chk("st_runs", runs, 3);
        chk("st_max", max_cycles, 40);
        chk("st_sat_max", s_max_cycles, 15);
`endif
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
